// File: rtl/rx_dbl_frame_buf_if.sv
// Handshake/bus bundle between SPI receiver, HDMI timing and the double frame buffer.
// RXBUF_TESTPAT_EN adds the TestPat colour-bar select signal.
interface rx_dbl_frame_buf_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 16
);
  logic              SPIDataValid;
  logic [DATA_W-1:0] SPIData;
  logic [ADDR_W-1:0] SPIDataAdd;
  logic              FrameDone;
  logic [1:0]        FraimSel;
  logic              FraimSync;
  logic              SwapPending;
  logic              PixelClk;
  logic              PixelCE;
  logic              HVsync;
  logic              HMemRead;
  logic [23:0]       HDMIdata;
`ifdef RXBUF_TESTPAT_EN
  logic              TestPat;

  modport master (
    output SPIDataValid, SPIData, SPIDataAdd, FrameDone, FraimSel, HVsync, HMemRead, TestPat,
    input  FraimSync, SwapPending, PixelClk, PixelCE, HDMIdata
  );
  modport slave (
    input  SPIDataValid, SPIData, SPIDataAdd, FrameDone, FraimSel, HVsync, HMemRead, TestPat,
    output FraimSync, SwapPending, PixelClk, PixelCE, HDMIdata
  );
`else
  modport master (
    output SPIDataValid, SPIData, SPIDataAdd, FrameDone, FraimSel, HVsync, HMemRead,
    input  FraimSync, SwapPending, PixelClk, PixelCE, HDMIdata
  );
  modport slave (
    input  SPIDataValid, SPIData, SPIDataAdd, FrameDone, FraimSel, HVsync, HMemRead,
    output FraimSync, SwapPending, PixelClk, PixelCE, HDMIdata
  );
`endif
endinterface

// File: rtl/rx_dbl_frame_buf.sv
// Double-buffered receive frame store: SPI writes one page while HDMI reads the other; pages swap at vsync.
// Optional RXBUF_TESTPAT_EN adds a TestPat input that substitutes 8 vertical colour bars for memory data.
module rx_dbl_frame_buf #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 38400,
  parameter int unsigned DIV       = 5,
  parameter int unsigned REP_SHIFT = 3
) (
  input  logic              Cclk,
  input  logic              rstn,
  rx_dbl_frame_buf_if.slave bus
);
  localparam int unsigned CW    = DATA_W / 3;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned HR_W  = ADDR_W + REP_SHIFT;
  localparam int unsigned MEM_N = 2 * DEPTH;
  localparam int unsigned IDX_W = $clog2(MEM_N);

  localparam logic [ADDR_W:0]   DEPTH_L      = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  PAGE1_BASE   = IDX_W'(DEPTH);
  localparam logic [HR_W-1:0]   LAST_WORD_HR = HR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD    = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF     = CNT_W'(DIV / 2);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pixel_ce;
  logic              pixel_clk;
  logic              hv_q;
  logic              swap_evt;
  logic              rd_page;
  logic              wr_page;
  logic              swap_pending;
  logic [HR_W-1:0]   hr_add;
  logic [HR_W-1:0]   hr_word;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] rd_data;
  logic [23:0]       mem_rgb;
  logic [23:0]       pix_rgb;
  logic [23:0]       hdmi_q;

  // Pixel divider: enable and divided clock are registered from the next count
  assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      pixel_ce  <= 1'b0;
      pixel_clk <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      pixel_ce  <= (cnt_nxt == '0);
      pixel_clk <= (cnt_nxt < CNT_HALF);
    end
  end

  // Page control: a completed frame is only shown from the next vsync falling edge
  assign swap_evt = hv_q & ~bus.HVsync;
  assign wr_page  = ~rd_page;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      hv_q         <= 1'b0;
      rd_page      <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      hv_q <= bus.HVsync;
      if (bus.FraimSel[1]) begin
        rd_page <= bus.FraimSel[0];
      end else if (swap_evt && swap_pending) begin
        rd_page <= ~rd_page;
      end
      if (bus.FrameDone) begin
        swap_pending <= 1'b1;
      end else if (!bus.FraimSel[1] && swap_evt) begin
        swap_pending <= 1'b0;
      end
    end
  end

  // Display read counter, held at zero through vertical sync
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      hr_add <= '0;
    end else if (!bus.HVsync) begin
      hr_add <= '0;
    end else if (pixel_ce && bus.HMemRead && (hr_add != '1)) begin
      hr_add <= hr_add + HR_W'(1);
    end
  end

  assign hr_word = hr_add >> REP_SHIFT;
  assign rd_addr = (hr_word >= LAST_WORD_HR) ? LAST_WORD : ADDR_W'(hr_word);

  assign wr_ok  = bus.SPIDataValid && ({1'b0, bus.SPIDataAdd} < DEPTH_L);
  assign wr_idx = wr_page ? (PAGE1_BASE + IDX_W'(bus.SPIDataAdd)) : IDX_W'(bus.SPIDataAdd);
  assign rd_idx = rd_page ? (PAGE1_BASE + IDX_W'(rd_addr)) : IDX_W'(rd_addr);

  always_ff @(posedge Cclk) begin
    if (wr_ok) begin
      mem[wr_idx] <= bus.SPIData;
    end
    rd_data <= mem[rd_idx];
  end

  // Each component widened to 8 bits with an all-ones fill below it
  always_comb begin
    mem_rgb             = '1;
    mem_rgb[23 -: CW]   = rd_data[DATA_W-1 -: CW];
    mem_rgb[15 -: CW]   = rd_data[2*CW-1 -: CW];
    mem_rgb[7 -: CW]    = rd_data[CW-1 -: CW];
  end

`ifdef RXBUF_TESTPAT_EN
  logic [2:0] tp_bar;

  always_ff @(posedge Cclk) begin
    tp_bar <= hr_add[REP_SHIFT+5 -: 3];
  end

  assign pix_rgb = bus.TestPat ? {{8{tp_bar[2]}}, {8{tp_bar[1]}}, {8{tp_bar[0]}}} : mem_rgb;
`else
  assign pix_rgb = mem_rgb;
`endif

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      hdmi_q <= '0;
    end else if (pixel_ce) begin
      hdmi_q <= bus.HMemRead ? pix_rgb : 24'h0;
    end
  end

  assign bus.PixelCE     = pixel_ce;
  assign bus.PixelClk    = pixel_clk;
  assign bus.FraimSync   = rd_page;
  assign bus.SwapPending = swap_pending;
  assign bus.HDMIdata    = hdmi_q;
endmodule

// File: tb/tb_rx_dbl_frame_buf.sv
// Randomised scoreboard bench for rx_dbl_frame_buf, modelled one pixel period at a time.
`timescale 1ns/1ps
module tb_rx_dbl_frame_buf;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DEPTH     = 40;
  localparam int unsigned DIV       = 5;
  localparam int unsigned REP_SHIFT = 3;
  localparam int          REP       = 1 << REP_SHIFT;

  logic Cclk = 1'b0;
  logic rstn = 1'b0;
  always #5 Cclk = ~Cclk;

  rx_dbl_frame_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rx_dbl_frame_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DIV(DIV), .REP_SHIFT(REP_SHIFT)
  ) dut (
    .Cclk(Cclk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        sync;
    logic        pend;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: two pages of words, shown page, pending flag, pixel counter
  logic [DATA_W-1:0] ref_mem [2][DEPTH];
  int                shown, pending, hr, prev_v;
  logic [1:0]        cur_sel;
  int                wa [DIV];
  logic [DATA_W-1:0] wd [DIV];
  bit                mon_ce;
  bit                rv, rr, rfd;
  int                rnw, rsel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [DATA_W-1:0] w);
    int c   = DATA_W / 3;
    int f   = 8 - c;
    int m   = (1 << c) - 1;
    int res = 0;
    for (int k = 2; k >= 0; k--) begin
      res = (res << 8) | ((((int'(w) >> (k * c)) & m) << f) | ((1 << f) - 1));
    end
    return 24'(res);
  endfunction

  function automatic void mwrite(input int a, input logic [DATA_W-1:0] d);
    if (a >= 0 && a < DEPTH) ref_mem[1 - shown][a] = d;
  endfunction

  task automatic drive_wr(input int j);
    bus.SPIDataValid = 1'b1;
    bus.SPIDataAdd   = ADDR_W'(wa[j]);
    bus.SPIData      = wd[j];
    mwrite(wa[j], wd[j]);
  endtask

  // One pixel period; inputs applied on the negedge where PixelCE is high
  task automatic slot(input bit v, input bit r, input bit fd, input logic [1:0] sel, input int nw);
    int   n = 0;
    int   idx;
    exp_t e;
    do begin
      @(negedge Cclk);
      n++;
    end while (!bus.PixelCE && n < 4 * DIV);
    if (!bus.PixelCE) begin
      checks++;
      errors++;
      $display("FAIL pixel_ce_timeout actual=0 required=1 at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "PixelCE never asserted");
    end
    idx = hr / REP;
    if (idx > DEPTH - 1) idx = DEPTH - 1;
    e.rgb = r ? expand(ref_mem[shown][idx]) : 24'h0;
    if (nw > 0) drive_wr(0);
    else bus.SPIDataValid = 1'b0;
    if (sel[1]) shown = int'(sel[0]);
    else if (prev_v == 1 && !v && pending == 1) begin
      shown   = 1 - shown;
      pending = 0;
    end
    if (fd) pending = 1;
    if (!v) hr = 0;
    else if (r) hr++;
    prev_v = int'(v);
    e.sync = shown[0];
    e.pend = pending[0];
    sb_q.push_back(e);
    bus.HVsync    = v;
    bus.HMemRead  = r;
    bus.FrameDone = fd;
    bus.FraimSel  = sel;
    for (int j = 1; j < DIV; j++) begin
      @(negedge Cclk);
      bus.FrameDone = 1'b0;
      if (j < nw) drive_wr(j);
      else bus.SPIDataValid = 1'b0;
    end
  endtask

  task automatic line(input int n, input bit r);
    for (int i = 0; i < n; i++) slot(1'b1, r, 1'b0, cur_sel, 0);
  endtask

  task automatic vsync(input bit fd);
    slot(1'b0, 1'b0, fd, cur_sel, 0);
    slot(1'b1, 1'b0, 1'b0, cur_sel, 0);
  endtask

  task automatic fill(input logic [DATA_W-1:0] first_word);
    int nw;
    for (int s = 0; s * DIV < DEPTH; s++) begin
      nw = DEPTH - s * DIV;
      if (nw > DIV) nw = DIV;
      for (int j = 0; j < nw; j++) begin
        wa[j] = s * DIV + j;
        wd[j] = DATA_W'($urandom);
      end
      if (s == 0) wd[0] = first_word;
      slot(1'b1, 1'b0, 1'b0, cur_sel, nw);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 8 * DIV) begin
      @(negedge Cclk);
      n++;
    end
    if (sb_q.size() > 0) chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every HDMIdata load (edge after PixelCE) pops one expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Cclk);
      if (mon_ce && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("hdmi_data", 32'(bus.HDMIdata), 32'(e.rgb));
        chk("fraim_sync", 32'(bus.FraimSync), 32'(e.sync));
        chk("swap_pending", 32'(bus.SwapPending), 32'(e.pend));
      end
      mon_ce = bus.PixelCE;
    end
  end

  initial begin : driver
    bus.SPIDataValid = 1'b0;
    bus.SPIData      = '0;
    bus.SPIDataAdd   = '0;
    bus.FrameDone    = 1'b0;
    bus.FraimSel     = 2'b00;
    bus.HVsync       = 1'b1;
    bus.HMemRead     = 1'b0;
`ifdef RXBUF_TESTPAT_EN
    bus.TestPat      = 1'b0;
`endif
    cur_sel = 2'b00;
    shown   = 0;
    pending = 0;
    hr      = 0;
    prev_v  = 1;

    repeat (3) @(posedge Cclk);
    #1;
    chk("rst_pixel_ce", 32'(bus.PixelCE), 32'd0);
    chk("rst_pixel_clk", 32'(bus.PixelClk), 32'd0);
    chk("rst_fraim_sync", 32'(bus.FraimSync), 32'd0);
    chk("rst_swap_pending", 32'(bus.SwapPending), 32'd0);
    chk("rst_hdmi_data", 32'(bus.HDMIdata), 32'd0);

    @(negedge Cclk);
    rstn = 1'b1;
    for (int i = 1; i <= 2 * DIV; i++) begin
      @(posedge Cclk);
      #1;
      chk("div_pixel_ce", 32'(bus.PixelCE), ((i % DIV) == 0) ? 32'd1 : 32'd0);
      chk("div_pixel_clk", 32'(bus.PixelClk), ((i % DIV) < (DIV / 2)) ? 32'd1 : 32'd0);
    end
    chk("idle_hdmi_data", 32'(bus.HDMIdata), 32'd0);

    // First frame into page 1, shown after vsync; line runs past page end to hit saturation
    fill(12'hABC);
    slot(1'b1, 1'b0, 1'b1, cur_sel, 0);
    vsync(1'b0);
    line(REP * DEPTH + 2 * REP, 1'b1);

    // Page 0 written without FrameDone: vsync must not swap
    fill(DATA_W'($urandom));
    vsync(1'b0);
    line(3 * REP, 1'b1);
    slot(1'b1, 1'b0, 1'b1, cur_sel, 0);
    vsync(1'b0);
    line(3 * REP, 1'b1);

    // Forced page 1, then back to automatic
    cur_sel = 2'b11;
    slot(1'b1, 1'b0, 1'b0, cur_sel, 0);
    for (int j = 0; j < DIV; j++) begin
      wa[j] = $urandom_range(0, DEPTH - 1);
      wd[j] = DATA_W'($urandom);
    end
    slot(1'b1, 1'b0, 1'b1, cur_sel, DIV);
    vsync(1'b0);
    line(2 * REP, 1'b1);
    vsync(1'b0);
    line(2 * REP, 1'b1);
    cur_sel = 2'b00;
    slot(1'b1, 1'b0, 1'b0, cur_sel, 0);
    vsync(1'b0);
    line(2 * REP, 1'b1);

    // FrameDone coincident with the vsync fall while already pending
    slot(1'b1, 1'b0, 1'b1, cur_sel, 0);
    vsync(1'b1);
    line(2 * REP, 1'b1);

    // Out-of-range writes are dropped; in-range edge addresses still land
    wa[0] = DEPTH;     wd[0] = 12'h123;
    wa[1] = 38400;     wd[1] = 12'h456;
    wa[2] = 65535;     wd[2] = 12'h789;
    wa[3] = 0;         wd[3] = 12'h5A3;
    wa[4] = DEPTH - 1; wd[4] = 12'h3C9;
    slot(1'b1, 1'b0, 1'b0, cur_sel, DIV);
    vsync(1'b0);
    line(REP * DEPTH + REP, 1'b1);
    slot(1'b1, 1'b0, 1'b1, cur_sel, 0);
    vsync(1'b0);
    line(2 * REP, 1'b1);

    // Random traffic
    for (int s = 0; s < 600; s++) begin
      rv   = ($urandom_range(0, 15) != 0);
      rr   = ($urandom_range(0, 3) != 0);
      rfd  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) begin
        rsel    = $urandom_range(0, 7);
        cur_sel = (rsel > 3) ? 2'b00 : 2'(rsel);
      end
      rnw = $urandom_range(0, DIV);
      for (int j = 0; j < DIV; j++) begin
        wa[j] = ($urandom_range(0, 15) == 0) ? (DEPTH + $urandom_range(0, 200)) : $urandom_range(0, DEPTH - 1);
        wd[j] = DATA_W'($urandom);
      end
      slot(rv, rr, rfd, cur_sel, rnw);
    end
    cur_sel = 2'b00;
    slot(1'b1, 1'b0, 1'b0, cur_sel, 0);
    vsync(1'b0);
    line(3 * REP, 1'b1);
    drain();

    // Asynchronous reset mid-line: state clears at once, memory survives
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_pixel_ce", 32'(bus.PixelCE), 32'd0);
    chk("mid_rst_pixel_clk", 32'(bus.PixelClk), 32'd0);
    chk("mid_rst_fraim_sync", 32'(bus.FraimSync), 32'd0);
    chk("mid_rst_swap_pending", 32'(bus.SwapPending), 32'd0);
    chk("mid_rst_hdmi_data", 32'(bus.HDMIdata), 32'd0);
    shown   = 0;
    pending = 0;
    hr      = 0;
    prev_v  = 1;
    @(negedge Cclk);
    rstn = 1'b1;
    line(3 * REP, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
